// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// MSB-first convention throughout: requester k lives at bit [3-k].
package arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  // Returns {found, idx}; searches last_ptr+1 .. last_ptr+4 (mod 4), nearest wins.
  function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] req,
                                         input logic [1:0]       last_ptr);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = last_ptr + 2'(i);
      if (req[2'd3 - cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic [1:0]       grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (output req, done,
                  input  grant, grant_idx, grant_valid, timeout);
  modport slave  (input  req, done,
                  output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/onehot_dec2to4.sv
// Combinational 2-bit index to MSB-first one-hot (0 -> 4'b1000 .. 3 -> 4'b0001).
// Zero latency, no flow control.
module onehot_dec2to4
  import arb_pkg::*;
(
  input  logic [1:0]       idx,
  output logic [N_REQ-1:0] onehot
);
  assign onehot = idx2onehot(idx);
endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin 4-way arbiter: one-cycle grant latency, grant held until done, withdrawal or hold limit.
// No backpressure; at least one idle cycle between owners, all outputs registered.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)
(
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       last_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [N_REQ-1:0] grant_q;
  logic [1:0]       idx_q;
  logic             valid_q;
  logic             timeout_q;

  logic             pick_found;
  logic [1:0]       pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic             owner_req;

  assign {pick_found, pick_idx} = rr_pick(bus.req, last_ptr);

  onehot_dec2to4 u_dec (
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  // grant_q is one-hot on the owner, so masking req with it isolates the owner's bit.
  assign owner_req = |(bus.req & grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_ptr  <= 2'd3;
      hold_cnt  <= '0;
      grant_q   <= '0;
      idx_q     <= 2'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= BUSY;
            grant_q  <= pick_oh;
            idx_q    <= pick_idx;
            valid_q  <= 1'b1;
            last_ptr <= pick_idx;
            hold_cnt <= '0;
          end
        end
        BUSY: begin
          if (bus.done || !owner_req || hold_cnt == HOLD_LAST) begin
            state     <= IDLE;
            grant_q   <= '0;
            idx_q     <= 2'd0;
            valid_q   <= 1'b0;
            hold_cnt  <= '0;
            timeout_q <= !bus.done && owner_req;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed and randomised checks of rr_arbiter4 with MAX_HOLD = 16.
module tb_rr_arbiter4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.MAX_HOLD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] gi,
                           input logic gv, input logic to);
    check(tag, {25'd0, bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout},
               {25'd0, g, gi, gv, to});
  endtask

  logic [3:0] rot_oh [4];
  logic [1:0] rot_idx [4];

  // random-phase reference state
  logic       m_busy;
  logic [1:0] m_idx;
  logic [1:0] m_last;
  int         m_hold;
  logic       m_to;
  logic [1:0] cand;
  logic [3:0] req_r;
  logic       done_r;
  logic       prev_valid;
  int         wait_cnt [4];

  initial begin
    total = 0;
    bad   = 0;
    rot_oh  = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    rot_idx = '{2'd1, 2'd2, 2'd3, 2'd0};

    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    #3;
    check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_out("idle_no_req", 4'b0000, 2'd0, 1'b0, 1'b0);

    // full request set: rotate 0,1,2,3,0 with one idle cycle between owners
    bus.req = 4'b1111;
    tick();
    check_out("first_grant", 4'b1000, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check_out("rot_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      tick();
      check_out("rot_grant", rot_oh[k], rot_idx[k], 1'b1, 1'b0);
    end
    bus.req  = 4'b0000;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check_out("done_in_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // timeout after 16 BUSY cycles, then re-grant to the same sole requester
    bus.req = 4'b0010;
    tick();
    check_out("to_grant", 4'b0010, 2'd2, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) tick();
    check_out("to_still_held", 4'b0010, 2'd2, 1'b1, 1'b0);
    tick();
    check_out("to_release", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    check_out("to_regrant", 4'b0010, 2'd2, 1'b1, 1'b0);

    // done coincident with the hold limit: release without timeout
    for (int k = 0; k < 15; k++) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    check_out("done_vs_timeout", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();

    // withdrawal by owner 1, then 3 beats 0 from last_ptr=1
    bus.req = 4'b0100;
    tick();
    check_out("wd_grant", 4'b0100, 2'd1, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    check_out("wd_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.req = 4'b1001;
    tick();
    check_out("wd_next_3", 4'b0001, 2'd3, 1'b1, 1'b0);
    bus.req = 4'b1111;
    tick();
    check_out("nonowner_ignored", 4'b0001, 2'd3, 1'b1, 1'b0);
    bus.req  = 4'b1001;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check_out("wd_then_0", 4'b1000, 2'd0, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b1111;
    tick();
    check_out("pre_rst_grant", 4'b0100, 2'd1, 1'b1, 1'b0);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_out("post_rst_grant", 4'b1000, 2'd0, 1'b1, 1'b0);

    // randomised traffic against a reference model, plus starvation bound
    rst_n = 1'b0;
    #2;
    rst_n      = 1'b1;
    m_busy     = 1'b0;
    m_idx      = 2'd0;
    m_last     = 2'd3;
    m_hold     = 0;
    prev_valid = 1'b0;
    req_r      = 4'b1111;
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) req_r[b] = ~req_r[b];
      done_r   = ($urandom_range(7) == 0);
      bus.req  = req_r;
      bus.done = done_r;
      m_to = 1'b0;
      if (m_busy) begin
        if (done_r) m_busy = 1'b0;
        else if (!req_r[3 - int'(m_idx)]) m_busy = 1'b0;
        else if (m_hold == 15) begin
          m_busy = 1'b0;
          m_to   = 1'b1;
        end else m_hold++;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          cand = m_last + 2'(k);
          if (!m_busy && req_r[3 - int'(cand)]) begin
            m_busy = 1'b1;
            m_idx  = cand;
            m_last = cand;
            m_hold = 0;
          end
        end
      end
      tick();
      check_out("rand_out", m_busy ? (4'b1000 >> m_idx) : 4'b0000,
                m_busy ? m_idx : 2'd0, m_busy, m_to);
      for (int k = 0; k < 4; k++)
        if (!req_r[3 - k]) wait_cnt[k] = 0;
      if (bus.grant_valid && !prev_valid) begin
        for (int k = 0; k < 4; k++) begin
          if (k == int'(bus.grant_idx)) wait_cnt[k] = 0;
          else if (req_r[3 - k]) begin
            wait_cnt[k]++;
            check("starve", {31'd0, wait_cnt[k] <= 3}, 32'd1);
          end
        end
      end
      prev_valid = bus.grant_valid;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
